// File: rtl/pipe_alu_if.sv
// Operand/result stream bundle for pipe_alu: one request channel, one response channel.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds
// its payload stable while valid is high and ready is low, and valid never waits on ready.
interface pipe_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, op, left, right, out_ready,
    input  in_ready, out_valid, out, zero, carry, busy
  );

  modport slave (
    input  in_valid, op, left, right, out_ready,
    output in_ready, out_valid, out, zero, carry, busy
  );
endinterface

// File: rtl/pipe_alu.sv
// Pipelined 16-operation integer ALU: the result is computed at accept time and then
// carried through LATENCY elastic stages that collapse bubbles and honour backpressure.
module pipe_alu #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  pipe_alu_if.slave   bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_LT   = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_LTS  = 4'd13;
  localparam logic [3:0] OP_MINU = 4'd14;
  localparam logic [3:0] OP_MAXU = 4'd15;

  localparam int               SH_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-2:0] PAD     = '0;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prod;
  logic [SH_W-1:0]  shift_amt;
  logic             shift_big;
  logic             lt_u;
  logic             lt_s;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             accept;

  logic [LATENCY-1:0]            valid_q, valid_d;
  logic [LATENCY-1:0]            adv;
  logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;
  logic [LATENCY-1:0]            zero_q, zero_d;
  logic [LATENCY-1:0]            carry_q, carry_d;

  assign sum_ext   = {1'b0, bus.left} + {1'b0, bus.right};
  assign diff      = bus.left - bus.right;
  assign prod      = bus.left * bus.right;
  assign shift_amt = bus.right[SH_W-1:0];
  assign shift_big = (bus.right >= WIDTH_V);
  assign lt_u      = (bus.left < bus.right);
  assign lt_s      = ($signed(bus.left) < $signed(bus.right));

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      OP_ADD:  begin alu_res = sum_ext[WIDTH-1:0]; alu_carry = sum_ext[WIDTH]; end
      OP_SUB:  begin alu_res = diff; alu_carry = lt_u; end
      OP_MUL:  alu_res = prod;
      OP_AND:  alu_res = bus.left & bus.right;
      OP_OR:   alu_res = bus.left | bus.right;
      OP_XOR:  alu_res = bus.left ^ bus.right;
      OP_NOT:  alu_res = ~bus.left;
      OP_SHL:  alu_res = shift_big ? '0 : (bus.left << shift_amt);
      OP_SHR:  alu_res = shift_big ? '0 : (bus.left >> shift_amt);
      // Oversized arithmetic shifts saturate to a full sign fill.
      OP_SRA:  alu_res = shift_big ? {WIDTH{bus.left[WIDTH-1]}}
                                   : WIDTH'($signed(bus.left) >>> shift_amt);
      OP_EQ:   alu_res = {PAD, (bus.left == bus.right)};
      OP_LT:   alu_res = {PAD, lt_u};
      OP_GT:   alu_res = {PAD, (bus.left > bus.right)};
      OP_LTS:  alu_res = {PAD, lt_s};
      OP_MINU: alu_res = lt_u ? bus.left : bus.right;
      OP_MAXU: alu_res = lt_u ? bus.right : bus.left;
      default: alu_res = '0;
    endcase
  end

  // A stage may move when any stage from it to the output is empty, or the consumer takes.
  function automatic logic stage_can_move(input int idx, input logic [LATENCY-1:0] v,
                                          input logic rdy);
    logic all_full;
    all_full = 1'b1;
    for (int j = idx; j < LATENCY; j++) all_full = all_full & v[j];
    return !all_full || rdy;
  endfunction

  always_comb begin
    for (int i = 0; i < LATENCY; i++) adv[i] = stage_can_move(i, valid_q, bus.out_ready);
  end

  assign accept = bus.in_valid && adv[0];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (adv[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0]  = alu_res;
        zero_d[0]  = (alu_res == '0);
        carry_d[0] = alu_carry;
      end
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i]  = data_q[i-1];
          zero_d[i]  = zero_q[i-1];
          carry_d[i] = carry_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
      zero_q  <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[LATENCY-1];
  assign bus.out       = data_q[LATENCY-1];
  assign bus.zero      = zero_q[LATENCY-1];
  assign bus.carry     = carry_q[LATENCY-1];
  assign bus.busy      = |valid_q;

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, pipelined, multi-operation integer ALU with valid/ready flow control. It is the sequential successor to the single-operation combinational arithmetic, logic, shift and compare primitives. It is used where a design needs a runtime-selected operation, a configurable latency, and backpressure-safe streaming. It sits between an operand producer and a result consumer that may stall.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- LATENCY, 3, register stages from accept to result (≥1); also the maximum number of results held in flight
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept this cycle
- op  in  4  operation select (see Operation)
- left  in  WIDTH  first operand
- right  in  WIDTH  second operand / shift amount
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- zero  out  1  out == 0 (valid with out_valid)
- carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops
- busy  out  1  any stage holds a valid entry

## Operation
- Ops: 0 ADD, 1 SUB, 2 MUL (low WIDTH bits of product), 3 AND, 4 OR, 5 XOR, 6 NOT (~left, right ignored), 7 SHL, 8 SHR logical, 9 SRA arithmetic, 10 EQ, 11 LT unsigned, 12 GT unsigned, 13 LTS signed, 14 MINU, 15 MAXU.
- Compare ops (10–13) return a 1-bit result zero-extended to WIDTH.
- Shifts: right is unsigned. If right ≥ WIDTH: SHL/SHR return 0, and SRA returns all bits equal to left[WIDTH-1].
- ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum. SUB: carry = 1 iff left < right unsigned.
- Result, zero and carry are computed combinationally from the accepted inputs, then registered into stage 0. Entries travel through stages 0..LATENCY-1. Stage LATENCY-1 drives out, zero, carry and out_valid.
- Each stage has a valid bit. Stage i advances when it is empty or when stage i+1 advances. The last stage advances on out_ready.
- Bubbles collapse: an empty stage always accepts from the stage behind it, even while the output is stalled.
- in_ready = !valid[0] || stage 0 advancing. This is a combinational path from out_ready, bounded by LATENCY.
- Acceptance happens when in_valid && in_ready. Results leave strictly in acceptance order, with no drop and no duplication.
- A stalled output holds out, zero and carry stable until handshake.
- busy = OR of all stage valid bits.

## Timing
- Reset low: all valid bits clear immediately, and all data and flag registers go to 0.
- In-flight entries are discarded by reset. No result appears for them after reset is released.
- Output values in reset: out_valid=0, out=0, zero=0, carry=0, busy=0, in_ready=1.
- Unstalled latency: an input accepted at edge N presents out_valid=1 in the cycle after edge N+LATENCY-1. That is, LATENCY edges including the capture edge.
- Throughput: 1 result/cycle with out_ready held high.
- Capacity: LATENCY entries. With out_ready low, in_ready drops after LATENCY accepts once all bubbles are squeezed out.
- Simultaneous out handshake and in accept when full: both occur in the same cycle, and the pipeline stays full.
- out_valid never depends combinationally on in_valid. Minimum in-to-out latency is LATENCY cycles.
- Registers hold when not advancing. Stage data does not change while its valid bit is set and it is stalled.

## Test plan
- WIDTH=8, LATENCY=3. ADD 200+100 → out=44, carry=1, zero=0, out_valid exactly 3 edges after accept. MUL 16×17 → out=16.
- SUB 5−5 → out=0, zero=1, carry=0. SUB 3−5 → out=254, carry=1.
- Shift and compare edges:
  - SRA 0x80 by 9 → 0xFF; SHR 0x80 by 9 → 0x00; SHL 0x01 by 7 → 0x80.
  - LTS 0xFF vs 0x01 → 1; LT 0xFF vs 0x01 → 0.
  - MAXU 0x7F vs 0x80 → 0x80.
- Backpressure: issue 6 back-to-back ADDs (i+1) with out_ready low from the first accept. in_ready falls after 3 accepts. Raise out_ready: results 1,2,3,4,5,6 appear in order, one per cycle, with none lost or repeated.
- Bubble collapse: in_valid on alternate cycles with out_ready low. Verify 3 entries are accepted and busy=1. Release out_ready: outputs are in order with no gaps beyond input gaps.
- Reset mid-operation: 2 entries in flight, pull reset low asynchronously between edges. out_valid and busy go to 0 before the next edge. After release, no stale result appears, and the next accepted ADD 1+1 returns 2 after 3 edges.
